// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, frame timing defaults and scheduler state encoding
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 12;
  localparam int UART_FRAME_TICKS = UART_FRAME_BITS + 2;
  typedef enum logic [2:0] {ST_FLUSH, ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick starting at i_ptr, with an optional lock owner taking precedence
module uart_rr_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  input  logic               i_lock_en,
  input  logic [IDW-1:0]     i_lock_id,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);
  logic [IDW:0] w_pos;
  // Scan from lowest to highest priority so the highest-priority valid requester is written last
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_any = |i_req;
    w_pos = '0;
    if (i_lock_en && i_req[i_lock_id]) begin
      o_grant[i_lock_id] = 1'b1;
      o_idx = i_lock_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
        w_pos = (w_pos >= (IDW+1)'(NUM_REQ)) ? w_pos - (IDW+1)'(NUM_REQ) : w_pos;
        if (i_req[w_pos[IDW-1:0]]) begin
          o_grant = '0;
          o_grant[w_pos[IDW-1:0]] = 1'b1;
          o_idx = w_pos[IDW-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one tick-clocked byte transmitter among NUM_REQ producers; optional UART_TX_SCHED_LOCK_EN adds req_lock
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_TICKS = UART_FRAME_TICKS,
  parameter int GAP_TICKS = 1,
  localparam int IDW = id_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_lock,
`endif
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           baud_tick,
  output logic                           tx_enable,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic [IDW-1:0]                 grant_id,
  output logic                           busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FRAME_TICKS + GAP_TICKS + 1);
  state_t r_state, w_state_nx;
  logic [BW-1:0] r_baud_cnt;
  logic [CW-1:0] r_tick_cnt, w_tick_nx;
  logic [IDW-1:0] r_rr_ptr, w_rr_nx, r_grant_id, w_grant_nx, w_idx;
  logic [UART_DATA_W-1:0] r_tx_data, w_tx_nx;
  logic [NUM_REQ-1:0] w_grant;
  logic w_any, w_lock_en, w_lock_hit, w_frame_last, w_gap_last;
`ifdef UART_TX_SCHED_LOCK_EN
  logic r_from_frame;
  // Remember that IDLE was just entered from a finished frame, the only moment a lock may re-grant its owner
  always_ff @(posedge clk)
    r_from_frame <= !reset && (r_state == ST_SEND || r_state == ST_GAP) && w_state_nx == ST_IDLE;
  assign w_lock_en = r_from_frame & req_lock[r_grant_id];
  assign w_lock_hit = w_lock_en & req_valid[r_grant_id];
`else
  assign w_lock_en = 1'b0;
  assign w_lock_hit = 1'b0;
`endif
  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req(req_valid),
    .i_ptr(r_rr_ptr),
    .i_lock_en(w_lock_en),
    .i_lock_id(r_grant_id),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign baud_tick = r_baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign w_frame_last = r_tick_cnt == CW'(FRAME_TICKS - 1);
  assign w_gap_last = r_tick_cnt == CW'(GAP_TICKS - 1);
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign tx_enable = r_state == ST_LOAD;
  assign tx_data = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy = r_state != ST_IDLE;
  // Free-running baud divider; the transmitter has no reset so only ours restarts the phase
  always_ff @(posedge clk)
    r_baud_cnt <= (reset || baud_tick) ? '0 : r_baud_cnt + 1'b1;
  // Next-state logic: flush, grant, one-tick load, timed frame, inter-frame gap
  always_comb begin
    w_state_nx = r_state;
    w_tick_nx = r_tick_cnt;
    w_rr_nx = r_rr_ptr;
    w_tx_nx = r_tx_data;
    w_grant_nx = r_grant_id;
    case (r_state)
      ST_FLUSH: if (baud_tick) begin
        w_tick_nx = w_frame_last ? '0 : r_tick_cnt + 1'b1;
        w_state_nx = w_frame_last ? ST_IDLE : ST_FLUSH;
      end
      ST_IDLE: if (w_any) begin
        w_state_nx = ST_LOAD;
        w_tx_nx = req_data[{w_idx, 3'b000} +: UART_DATA_W];
        w_grant_nx = w_idx;
        w_rr_nx = w_lock_hit ? r_rr_ptr : (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      ST_LOAD: if (baud_tick) begin
        w_state_nx = ST_SEND;
        w_tick_nx = '0;
      end
      ST_SEND: if (baud_tick) begin
        w_tick_nx = w_frame_last ? '0 : r_tick_cnt + 1'b1;
        w_state_nx = !w_frame_last ? ST_SEND : (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: if (baud_tick) begin
        w_tick_nx = w_gap_last ? '0 : r_tick_cnt + 1'b1;
        w_state_nx = w_gap_last ? ST_IDLE : ST_GAP;
      end
      default: w_state_nx = ST_FLUSH;
    endcase
  end
  // State and datapath registers; reset lands in FLUSH to drain any frame the transmitter is still sending
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FLUSH;
      r_tick_cnt <= '0;
      r_rr_ptr <= '0;
      r_tx_data <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tick_cnt <= w_tick_nx;
      r_rr_ptr <= w_rr_nx;
      r_tx_data <= w_tx_nx;
      r_grant_id <= w_grant_nx;
    end
  end
endmodule
